step_run_ctrl: RTL and testbench

STEP_RUN_CTRL -- requirements
Module: step_run_ctrl

---
 rtl/step_run_ctrl_if.sv | 28 ++
 rtl/step_run_ctrl.sv | 135 +++++++++++++
 tb/tb_step_run_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/step_run_ctrl_if.sv
// Step/run controller handshake bundle.
// Ports: button, run, halt in; step_en, step_cnt, busy out (slave view).
interface step_run_ctrl_if;
    logic        button;
    logic        run;
    logic        halt;
    logic        step_en;
    logic [15:0] step_cnt;
    logic        busy;

    modport master (
        output button,
        output run,
        output halt,
        input  step_en,
        input  step_cnt,
        input  busy
    );

    modport slave (
        input  button,
        input  run,
        input  halt,
        output step_en,
        output step_cnt,
        output busy
    );
endinterface

// File: rtl/step_run_ctrl.sv
// Debounced single-step / free-run clock-enable generator for a PCPU.
// Ports: clk, reset (async, high); bus: button/run/halt in, step_en/step_cnt/busy out.
module step_run_ctrl #(
    parameter logic [15:0] DB_CYCLES = 16'd50000,
    parameter logic [15:0] RUN_DIV   = 16'd4
) (
    input logic            clk,
    input logic            reset,
    step_run_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CHK_PRESS,
        HELD,
        CHK_REL
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] db_cnt;
    logic [15:0] db_cnt_nx;
    logic        press_evt;

    logic        btn_m;
    logic        btn_s;
    logic        run_m;
    logic        run_s;

    logic [15:0] div_cnt;
    logic        div_tc;
    logic        step_nx;
    logic        step_en;
    logic [15:0] step_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            run_m <= 1'b0;
            run_s <= 1'b0;
        end else begin
            btn_m <= bus.button;
            btn_s <= btn_m;
            run_m <= bus.run;
            run_s <= run_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            db_cnt <= 16'd0;
        end else begin
            state  <= state_nx;
            db_cnt <= db_cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        db_cnt_nx = db_cnt;
        press_evt = 1'b0;
        unique case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nx  = CHK_PRESS;
                    db_cnt_nx = 16'd0;
                end
            end
            CHK_PRESS: begin
                if (!btn_s) begin
                    state_nx = IDLE;
                end else if (db_cnt == DB_CYCLES - 16'd1) begin
                    state_nx  = HELD;
                    press_evt = 1'b1;
                end else begin
                    db_cnt_nx = db_cnt + 16'd1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nx  = CHK_REL;
                    db_cnt_nx = 16'd0;
                end
            end
            CHK_REL: begin
                if (btn_s) begin
                    state_nx = HELD;
                end else if (db_cnt == DB_CYCLES - 16'd1) begin
                    state_nx = IDLE;
                end else begin
                    db_cnt_nx = db_cnt + 16'd1;
                end
            end
            default: begin
                state_nx  = IDLE;
                db_cnt_nx = 16'd0;
            end
        endcase
    end

    // Divider parks at 0 in single-step so leaving run mode drops
    // any partial count without producing a pulse.
    assign div_tc = run_s && (div_cnt == RUN_DIV - 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= 16'd0;
        end else if (!run_s || div_tc) begin
            div_cnt <= 16'd0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Mode selects exactly one pulse source, so a press coinciding
    // with terminal count can never yield two pulses.
    assign step_nx = !bus.halt && (run_s ? div_tc : press_evt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_en  <= 1'b0;
            step_cnt <= 16'd0;
        end else begin
            step_en  <= step_nx;
            step_cnt <= step_cnt + {15'd0, step_en};
        end
    end

    assign bus.step_en  = step_en;
    assign bus.step_cnt = step_cnt;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_step_run_ctrl.sv
// Directed bench for step_run_ctrl (DB_CYCLES=4, RUN_DIV=3, plus RUN_DIV=1 copy).
// Ports: drives both instances through their interfaces; prints one summary line.
module tb_step_run_ctrl;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   pulses;
    int   base;

    step_run_ctrl_if ifc ();
    step_run_ctrl_if ifc2 ();

    step_run_ctrl #(
        .DB_CYCLES(16'd4),
        .RUN_DIV  (16'd3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    step_run_ctrl #(
        .DB_CYCLES(16'd4),
        .RUN_DIV  (16'd1)
    ) dut2 (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (ifc.step_en === 1'b1) pulses++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        ifc.button = 1'b0;
        ifc.run    = 1'b0;
        ifc.halt   = 1'b0;
        reset      = 1'b1;
        cyc(2);
        reset      = 1'b0;
        cyc(1);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        pulses      = 0;
        ifc2.button = 1'b0;
        ifc2.run    = 1'b0;
        ifc2.halt   = 1'b0;

        // reset state
        ifc.button = 1'b0;
        ifc.run    = 1'b0;
        ifc.halt   = 1'b0;
        reset      = 1'b1;
        cyc(2);
        chk("rst_step_en", 32'(ifc.step_en), 32'd0);
        chk("rst_step_cnt", 32'(ifc.step_cnt), 32'd0);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        reset = 1'b0;
        cyc(1);

        // bouncy press then solid hold
        base = pulses;
        for (int i = 0; i < 6; i++) begin
            ifc.button = (i % 2 == 0);
            cyc(1);
        end
        ifc.button = 1'b1;
        cyc(10);
        chk("bounce_busy_held", 32'(ifc.busy), 32'd1);
        ifc.button = 1'b0;
        cyc(10);
        chk("bounce_pulses", 32'(pulses - base), 32'd1);
        chk("bounce_cnt", 32'(ifc.step_cnt), 32'd1);
        chk("bounce_busy_rel", 32'(ifc.busy), 32'd0);

        // long hold, release, press again
        do_reset();
        base       = pulses;
        ifc.button = 1'b1;
        cyc(6);
        chk("press_pre", 32'(ifc.step_en), 32'd0);
        cyc(1);
        chk("press_edge", 32'(ifc.step_en), 32'd1);
        cyc(1);
        chk("press_one_wide", 32'(ifc.step_en), 32'd0);
        chk("press_cnt1", 32'(ifc.step_cnt), 32'd1);
        cyc(92);
        chk("hold_no_repeat", 32'(pulses - base), 32'd1);
        chk("hold_busy", 32'(ifc.busy), 32'd1);
        ifc.button = 1'b0;
        cyc(10);
        chk("rel_busy", 32'(ifc.busy), 32'd0);
        ifc.button = 1'b1;
        cyc(10);
        ifc.button = 1'b0;
        cyc(10);
        chk("two_pulses", 32'(pulses - base), 32'd2);
        chk("two_cnt", 32'(ifc.step_cnt), 32'd2);
        chk("two_busy", 32'(ifc.busy), 32'd0);

        // free run, press ignored
        do_reset();
        base       = pulses;
        ifc.run    = 1'b1;
        ifc.button = 1'b1;
        cyc(2);
        cyc(30);
        chk("run_pulses", 32'(pulses - base), 32'd10);
        chk("run_fsm_tracks", 32'(ifc.busy), 32'd1);
        ifc.run    = 1'b0;
        ifc.button = 1'b0;
        cyc(12);
        chk("run_stop_pulses", 32'(pulses - base), 32'd10);
        chk("run_cnt", 32'(ifc.step_cnt), 32'd10);

        // leaving run mid-count gives no pulse
        ifc.run = 1'b1;
        cyc(5);
        chk("rerun_first", 32'(ifc.step_en), 32'd1);
        ifc.run = 1'b0;
        cyc(6);
        chk("midcount_clear", 32'(pulses - base), 32'd11);

        // halt in run mode, then press during halt
        do_reset();
        base     = pulses;
        ifc.halt = 1'b1;
        ifc.run  = 1'b1;
        cyc(11);
        chk("halt_run_none", 32'(pulses - base), 32'd0);
        ifc.halt = 1'b0;
        cyc(2);
        chk("unhalt_pre", 32'(ifc.step_en), 32'd0);
        cyc(1);
        chk("unhalt_pulse", 32'(ifc.step_en), 32'd1);
        base       = pulses;
        ifc.run    = 1'b0;
        ifc.halt   = 1'b1;
        ifc.button = 1'b1;
        cyc(10);
        ifc.halt = 1'b0;
        cyc(10);
        ifc.button = 1'b0;
        cyc(10);
        chk("halt_press_drop", 32'(pulses - base), 32'd0);
        chk("halt_cnt", 32'(ifc.step_cnt), 32'd1);

        // reset mid-debounce
        do_reset();
        base       = pulses;
        ifc.button = 1'b1;
        cyc(5);
        chk("mid_db_busy", 32'(ifc.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_busy", 32'(ifc.busy), 32'd0);
        chk("async_step_en", 32'(ifc.step_en), 32'd0);
        ifc.button = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(12);
        chk("abort_no_pulse", 32'(pulses - base), 32'd0);
        chk("abort_busy", 32'(ifc.busy), 32'd0);

        // release reset with button already high
        ifc.button = 1'b1;
        reset      = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(6);
        chk("rel_high_pre", 32'(ifc.step_en), 32'd0);
        chk("rel_high_busy", 32'(ifc.busy), 32'd1);
        cyc(1);
        chk("rel_high_pulse", 32'(ifc.step_en), 32'd1);
        ifc.button = 1'b0;
        cyc(10);

        // RUN_DIV=1: continuous enable, counter wrap
        ifc2.run = 1'b1;
        cyc(8);
        chk("div1_cnt5", 32'(ifc2.step_cnt), 32'd5);
        chk("div1_level", 32'(ifc2.step_en), 32'd1);
        cyc(65531);
        chk("div1_wrap", 32'(ifc2.step_cnt), 32'd0);
        chk("div1_still_on", 32'(ifc2.step_en), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
